conv_encoder: RTL and testbench
===============================

# conv_encoder

Rate-1/2, constraint-length-3 convolutional encoder; transmit-side counterpart of the Viterbi decoder's 4-state trellis and traceback unit. Accepts a frame of serial information bits over a valid/ready handshake and emits one 2-bit coded symbol per bit. It zero-terminates each frame with tail bits so the decoder traceback starts and ends in state 0. Sits between the test source/scrambler and the channel model/BMU.

## Interface
- `FRAME_LEN`, 64: information bits per frame, range 1 to 2^CNT_W-1.
- `CNT_W`, 8: bit-counter width.
- `G0`, 3'b111: generator polynomial for `sym_o[1]`; bit 2 taps input, bit 1 taps s[1], bit 0 taps s[0].
- `G1`, 3'b101: generator polynomial for `sym_o[0]`, same tap order.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  single-cycle frame start; honoured only in IDLE.
- `data_i`  in  1  information bit.
- `valid_i`  in  1  `data_i` valid.
- `ready_o`  out  1  encoder accepts `data_i` this cycle.
- `sym_o`  out  2  coded symbol {G0 bit, G1 bit}.
- `sym_valid_o`  out  1  `sym_o` valid.
- `sym_ready_i`  in  1  downstream accepts `sym_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `frame_done_o`  out  1  single-cycle pulse at frame end.

## Operation
- Encoder state s[1:0], s[1] is the most recent bit. Next state is {in, s[1]}, matching the decoder trellis in which states 0/1 are predecessors of 0 and 2.
- Output bits: `sym_o[1]` = ^(G0 & {in,s}); `sym_o[0]` = ^(G1 & {in,s}).
- An input transfer occurs when `valid_i & ready_o`. An output transfer occurs when `sym_valid_o & sym_ready_i`.
- The output slot is free when `!sym_valid_o | sym_ready_i`.
- `ready_o` = (state==DATA) & slot free. It is purely combinational from registered state and `sym_ready_i`.
- FSM states:
  - IDLE: `start_i` clears s to 0 and the bit counter to 0, then goes to DATA. Any other input is ignored.
  - DATA: each input transfer loads `sym_o` and sets `sym_valid_o`, updates s, and increments the counter. On the FRAME_LEN-th transfer, go to TAIL (or DRAIN if tail is compiled out).
  - TAIL: while the slot is free, encode in=0 and load a symbol. After 2 tail symbols are loaded, go to DRAIN.
  - DRAIN: wait for the final output transfer. Then pulse `frame_done_o` for 1 cycle and return to IDLE.
- Counter width rules: compare the counter to FRAME_LEN-1 at CNT_W bits. The counter never wraps inside a frame.
- While `sym_valid_o & !sym_ready_i`, `sym_o` and `sym_valid_o` are held stable. No input transfer and no tail generation occur in that cycle.
- If an output transfer and a new load happen in the same cycle, the new symbol replaces the old one and `sym_valid_o` stays high.
- `start_i` outside IDLE has no effect.
- Reset mid-frame: the partial frame is discarded and all outputs return to reset values.

## Timing
- Reset values:
  - `ready_o` = 0, `sym_o` = 2'b00, `sym_valid_o` = 0.
  - `busy_o` = 0, `frame_done_o` = 0.
  - FSM = IDLE, s = 0, counter = 0.
- Start latency: `start_i` in cycle N gives `busy_o` = 1 and `ready_o` = 1 (if `sym_ready_i`) in cycle N+1.
- Encode latency: input transfer in cycle N gives `sym_valid_o` = 1 with the corresponding symbol in cycle N+1.
- Throughput: 1 symbol/cycle with `sym_ready_i` held high. A frame occupies FRAME_LEN+2 symbol cycles with tail, FRAME_LEN without.
- Frame end: `frame_done_o` is high for 1 cycle, in the cycle after the last output transfer. `busy_o` falls in that same cycle.
- A new `start_i` is accepted in the `frame_done_o` cycle or later.

## Configuration
- Macro `CONV_ENC_TAIL_EN`.
- Defined: 2 zero tail bits are appended per frame, and s ends at 0.
- Undefined: TAIL state is removed and DATA goes directly to DRAIN. s is cleared only by `start_i`. The frame is FRAME_LEN symbols long and the decoder must not assume termination.

## Test plan
- Basic frame: FRAME_LEN=4, tail enabled, bits 1,0,1,1, `sym_ready_i`=1 → symbols 11,10,00,01,01,11. `frame_done_o` pulses 1 cycle after the last symbol.
- Backpressure: same frame with `sym_ready_i` low for 3 cycles after the 2nd symbol. Required: `sym_o`=10 held stable, `ready_o`=0 throughout, and the final sequence is unchanged.
- Input gaps: `valid_i` toggles 1,0,0,1,… → symbol sequence identical to the basic frame. No symbol is produced on idle cycles.
- Reset mid-frame: assert `rst_n`=0 after 2 symbols. Required: all outputs at reset values immediately. A following frame 1,0,1,1 gives 11,10,00,01,01,11.
- Spurious start: `start_i` pulsed while in DATA → no counter or state change, and the frame completes normally.
- Tail compiled out, FRAME_LEN=4, bits 1,0,1,1 → 11,10,00,01, then `frame_done_o`. The next frame starting with bit 1 outputs 11.

Source files
------------

// File: rtl/conv_encoder_if.sv
`default_nettype none
// ------------------------------------------------------------
// conv_encoder_if : bit-in / symbol-out handshake bundle
// Rev 1.0
// ------------------------------------------------------------
interface conv_encoder_if;
   logic       start_i;
   logic       data_i;
   logic       valid_i;
   logic       ready_o;
   logic [1:0] sym_o;
   logic       sym_valid_o;
   logic       sym_ready_i;
   logic       busy_o;
   logic       frame_done_o;

   modport master (
      output start_i, data_i, valid_i, sym_ready_i,
      input  ready_o, sym_o, sym_valid_o, busy_o, frame_done_o
   );

   modport slave (
      input  start_i, data_i, valid_i, sym_ready_i,
      output ready_o, sym_o, sym_valid_o, busy_o, frame_done_o
   );
endinterface
`default_nettype wire

// File: rtl/conv_encoder.sv
`default_nettype none
// ------------------------------------------------------------
// conv_encoder : rate-1/2, K=3 convolutional encoder with optional
// zero-tail termination (macro CONV_ENC_TAIL_EN). Rev 1.0
// ------------------------------------------------------------
module conv_encoder #(
   parameter int         FRAME_LEN = 64,
   parameter int         CNT_W     = 8,
   parameter logic [2:0] G0        = 3'b111,
   parameter logic [2:0] G1        = 3'b101
) (
   input  logic          clk,
   input  logic          rst_n,
   conv_encoder_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DATA  = 2'd1,
`ifdef CONV_ENC_TAIL_EN
      ST_TAIL  = 2'd2,
`endif
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(FRAME_LEN - 1);

   state_t           r_state;
   logic [1:0]       r_s;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_sym;
   logic             r_sym_valid;
   logic             r_busy;
   logic             r_frame_done;
`ifdef CONV_ENC_TAIL_EN
   logic             r_tail_cnt;
`endif

   logic w_slot_free;
   logic w_ready;
   logic w_in_xfer;
   logic w_out_xfer;

   function automatic logic [1:0] encode(input logic in_bit, input logic [1:0] st);
      logic [2:0] taps;
      taps = {in_bit, st};
      return {^(G0 & taps), ^(G1 & taps)};
   endfunction

   assign w_slot_free = !r_sym_valid || bus.sym_ready_i;
   assign w_ready     = (r_state == ST_DATA) && w_slot_free;
   assign w_in_xfer   = bus.valid_i && w_ready;
   assign w_out_xfer  = r_sym_valid && bus.sym_ready_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_s          <= 2'b00;
         r_cnt        <= '0;
         r_sym        <= 2'b00;
         r_sym_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
         r_tail_cnt   <= 1'b0;
`endif
      end else begin
         r_frame_done <= 1'b0;
         // A load below overrides this clear, keeping valid high back-to-back
         if (w_out_xfer) r_sym_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.start_i) begin
                  r_s     <= 2'b00;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_in_xfer) begin
                  r_sym       <= encode(bus.data_i, r_s);
                  r_sym_valid <= 1'b1;
                  r_s         <= {bus.data_i, r_s[1]};
                  r_cnt       <= r_cnt + 1'b1;
                  if (r_cnt == C_LAST) begin
`ifdef CONV_ENC_TAIL_EN
                     r_tail_cnt <= 1'b0;
                     r_state    <= ST_TAIL;
`else
                     r_state    <= ST_DRAIN;
`endif
                  end
               end
            end
`ifdef CONV_ENC_TAIL_EN
            ST_TAIL: begin
               if (w_slot_free) begin
                  r_sym       <= encode(1'b0, r_s);
                  r_sym_valid <= 1'b1;
                  r_s         <= {1'b0, r_s[1]};
                  r_tail_cnt  <= 1'b1;
                  if (r_tail_cnt) r_state <= ST_DRAIN;
               end
            end
`endif
            ST_DRAIN: begin
               if (w_out_xfer) begin
                  r_frame_done <= 1'b1;
                  r_busy       <= 1'b0;
                  r_state      <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.ready_o      = w_ready;
   assign bus.sym_o        = r_sym;
   assign bus.sym_valid_o  = r_sym_valid;
   assign bus.busy_o       = r_busy;
   assign bus.frame_done_o = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder.sv
`default_nettype none
// ------------------------------------------------------------
// tb_conv_encoder : directed frames with a queued scoreboard
// Rev 1.0
// ------------------------------------------------------------
module tb_conv_encoder;

`ifdef CONV_ENC_TAIL_EN
   localparam int NSYM = 6;
`else
   localparam int NSYM = 4;
`endif
   localparam logic [1:0] EXP [0:5] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};

   logic clk;
   logic rst_n;
   conv_encoder_if bus();

   conv_encoder #(.FRAME_LEN(4), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int         errors = 0;
   int         checks = 0;
   logic [1:0] exp_q[$];
   logic       exp_done = 1'b0;
   logic [3:0] frame_bits = 4'b1101;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: pops the scoreboard on each output transfer
   initial begin
      logic [1:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_done = 1'b0;
         end else begin
            if (exp_done || bus.frame_done_o) begin
               check("frame_done", 8'(bus.frame_done_o), 8'(exp_done));
               if (exp_done) check("busy_at_done", 8'(bus.busy_o), 8'd0);
               exp_done = 1'b0;
            end
            if (bus.sym_valid_o && bus.sym_ready_i) begin
               if (exp_q.size() == 0) begin
                  check("extra_symbol", 8'(bus.sym_o), 8'hff);
               end else begin
                  e = exp_q.pop_front();
                  check("symbol", 8'(bus.sym_o), 8'(e));
                  if (exp_q.size() == 0) exp_done = 1'b1;
               end
            end
         end
      end
   end

   task automatic wait_done();
      bit seen = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.frame_done_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) check("done_timeout", 8'd0, 8'd1);
      @(posedge clk); #1;
   endtask

   task automatic send_frame(input int gap, input int bp_after, input int abort_after,
                             input bit spurious);
      bit acc;
      bit ok;
      for (int k = 0; k < NSYM; k++) exp_q.push_back(EXP[k]);
      bus.start_i = 1'b1;
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      #3;
      check("start_busy", 8'(bus.busy_o), 8'd1);
      check("start_ready", 8'(bus.ready_o), 8'd1);
      for (int i = 0; i < 4; i++) begin
         if (i > 0) repeat (gap) begin
            @(posedge clk); #1;
         end
         bus.valid_i = 1'b1;
         bus.data_i  = frame_bits[i];
         if (spurious && i == 1) bus.start_i = 1'b1;
         ok = 1'b0;
         for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            acc = bus.ready_o;
            @(posedge clk); #1;
            if (acc) begin
               ok = 1'b1;
               break;
            end
         end
         bus.start_i = 1'b0;
         bus.valid_i = 1'b0;
         if (!ok) check("accept_timeout", 8'd0, 8'd1);
         if (spurious && i == 1) check("spurious_busy", 8'(bus.busy_o), 8'd1);
         if (i + 1 == bp_after) begin
            bus.sym_ready_i = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_sym", 8'(bus.sym_o), 8'(EXP[1]));
               check("bp_valid", 8'(bus.sym_valid_o), 8'd1);
               check("bp_ready", 8'(bus.ready_o), 8'd0);
               @(posedge clk); #1;
            end
            bus.sym_ready_i = 1'b1;
         end
         if (i + 1 == abort_after) begin
            @(posedge clk); #1;
            rst_n = 1'b0;
            exp_q.delete();
            #1;
            check("rst_ready", 8'(bus.ready_o), 8'd0);
            check("rst_sym", 8'(bus.sym_o), 8'd0);
            check("rst_sym_valid", 8'(bus.sym_valid_o), 8'd0);
            check("rst_busy", 8'(bus.busy_o), 8'd0);
            check("rst_frame_done", 8'(bus.frame_done_o), 8'd0);
            return;
         end
      end
      wait_done();
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.start_i     = 1'b0;
      bus.data_i      = 1'b0;
      bus.valid_i     = 1'b0;
      bus.sym_ready_i = 1'b1;
      #12;
      check("reset_ready", 8'(bus.ready_o), 8'd0);
      check("reset_sym", 8'(bus.sym_o), 8'd0);
      check("reset_sym_valid", 8'(bus.sym_valid_o), 8'd0);
      check("reset_busy", 8'(bus.busy_o), 8'd0);
      check("reset_frame_done", 8'(bus.frame_done_o), 8'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      send_frame(0, 0, 0, 1'b0);   // basic
      send_frame(0, 0, 0, 1'b0);   // back-to-back, restarts from s=0
      send_frame(0, 2, 0, 1'b0);   // backpressure
      send_frame(2, 0, 0, 1'b0);   // input gaps
      send_frame(0, 0, 2, 1'b0);   // reset mid-frame
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      send_frame(0, 0, 0, 1'b0);   // frame after reset
      send_frame(1, 0, 0, 1'b1);   // spurious start in DATA

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", 8'(exp_q.size()), 8'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
